// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block copy of 64-bit doublewords between data-memory regions
// Ports: clk/reset_n (sync, active-low); start, src_addr, dst_addr, count request a copy;
// busy, done, err, words_done report status; mem_read, mem_write, address, mem_wdata
// drive the memory port and mem_rdata returns combinational read data.
module mem_copy_engine #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [63:0]      src_addr,
  input  logic [63:0]      dst_addr,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_done,
  output logic             mem_read,
  output logic             mem_write,
  output logic [63:0]      address,
  output logic [63:0]      mem_wdata,
  input  logic [63:0]      mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t           state_q, state_d;
  logic [63:0]      src_q, src_d, dst_q, dst_d, buf_q, buf_d;
  logic [CNT_W-1:0] rem_q, rem_d, words_q, words_d;
  logic             err_q, err_d, unaligned;
  assign unaligned = |{src_addr[2:0], dst_addr[2:0]};
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    rem_d   = rem_q;
    words_d = words_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        src_d   = src_addr;
        dst_d   = dst_addr;
        rem_d   = count;
        words_d = '0;
        err_d   = unaligned;
        state_d = (unaligned || count == '0) ? DONE : READ;
      end
      READ: begin
        buf_d   = mem_rdata;
        src_d   = src_q + 64'd8;
        state_d = WRITE;
      end
      WRITE: begin
        dst_d   = dst_q + 64'd8;
        rem_d   = rem_q - CNT_W'(1);
        words_d = words_q + CNT_W'(1);
        state_d = (rem_q == CNT_W'(1)) ? DONE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy       = (state_q == READ) || (state_q == WRITE);
  assign done       = state_q == DONE;
  assign err        = err_q;
  assign words_done = words_q;
  // strobes are gated by reset directly so a write cannot commit on the reset edge
  assign mem_read   = reset_n && state_q == READ;
  assign mem_write  = reset_n && state_q == WRITE;
  assign address    = (state_q == READ) ? src_q : (state_q == WRITE) ? dst_q : 64'd0;
  assign mem_wdata  = (state_q == WRITE) ? buf_q : 64'd0;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed and randomized copies checked against an array-level copy model
module tb_mem_copy_engine;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] src_addr = '0, dst_addr = '0;
  logic [15:0] count = '0;
  logic        busy, done, err, mem_read, mem_write;
  logic [15:0] words_done;
  logic [63:0] address, mem_wdata, mem_rdata;
  logic [63:0] mem [256];
  logic [63:0] img [256];
  bit          fill = 1'b0;
  int          passed = 0, total = 0, fails = 0;

  always #5 clk = ~clk;

  mem_copy_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .count(count), .busy(busy), .done(done), .err(err), .words_done(words_done),
    .mem_read(mem_read), .mem_write(mem_write), .address(address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk)
    if (fill) mem <= img;
    else if (mem_write) mem[address[10:3]] <= mem_wdata;
  assign mem_rdata = mem[address[10:3]];

  function automatic logic [7:0] ix(input logic [63:0] a);
    return a[10:3];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int n_fixed);
    for (int i = 0; i < 256; i++) img[i] = (i < n_fixed) ? 64'(i) : {$urandom, $urandom};
    fill = 1'b1;
    @(posedge clk); #1;
    fill = 1'b0;
  endtask

  task automatic run(input string tag, input logic [63:0] s, input logic [63:0] d, input int n, input bit poke);
    logic [63:0] model [256];
    logic [63:0] exp_w [$];
    logic [63:0] v;
    bit bad;
    int nn, k, done_at, done_cnt, busy_cnt, seq_err, mem_err;
    bad = (s[2:0] != 0) || (d[2:0] != 0);
    nn = bad ? 0 : n;
    done_at = 0; done_cnt = 0; busy_cnt = 0; seq_err = 0; mem_err = 0;
    model = mem;
    for (int j = 0; j < nn; j++) begin
      v = model[ix(s + 64'(8 * j))];
      exp_w.push_back(v);
      model[ix(d + 64'(8 * j))] = v;
    end
    start = 1'b1; src_addr = s; dst_addr = d; count = 16'(n);
    @(posedge clk); #1;
    for (int c = 1; c <= 2 * nn + 4; c++) begin
      if (poke && c == 3) begin
        start = 1'b1; src_addr = s + 64'h40; dst_addr = d + 64'h80; count = 16'd7;
      end else start = 1'b0;
      if (done) begin done_cnt++; done_at = c; end
      if (busy) busy_cnt++;
      if (mem_read && mem_write) seq_err++;
      if (c <= 2 * nn) begin
        k = (c - 1) / 2;
        if (c % 2 == 1) begin
          if (!mem_read || address !== s + 64'(8 * k)) seq_err++;
        end else if (!mem_write || address !== d + 64'(8 * k) || mem_wdata !== exp_w[k]) seq_err++;
      end else if (mem_read || mem_write || address !== 64'd0 || mem_wdata !== 64'd0) seq_err++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model[i]) mem_err++;
    check({tag, "/done_at"}, 64'(done_at), 64'(2 * nn + 1));
    check({tag, "/done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(2 * nn));
    check({tag, "/bus_seq"}, 64'(seq_err), 64'd0);
    check({tag, "/words_done"}, 64'(words_done), 64'(nn));
    check({tag, "/err"}, 64'(err), 64'(bad));
    check({tag, "/mem"}, 64'(mem_err), 64'd0);
  endtask

  initial begin
    int dc;
    repeat (2) @(posedge clk);
    #1;
    check("reset/strobes_low", {62'd0, mem_read, mem_write}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("reset/status", {45'd0, busy, done, err, words_done}, 64'd0);
    check("reset/bus", address | mem_wdata, 64'd0);

    preload(4);
    run("basic", 64'h0, 64'h100, 4, 1'b0);
    preload(4);
    run("zero", 64'h0, 64'h100, 0, 1'b0);
    run("unaligned_src", 64'h4, 64'h100, 2, 1'b0);
    run("unaligned_dst", 64'h0, 64'h102, 2, 1'b0);
    run("after_err", 64'h0, 64'h180, 1, 1'b0);
    preload(3);
    run("overlap", 64'h0, 64'h8, 2, 1'b0);
    check("overlap/mem8", mem[1], 64'd0);
    check("overlap/mem10", mem[2], 64'd0);
    preload(0);
    run("busy_start", 64'h40, 64'h300, 3, 1'b1);
    run("wrap", 64'hFFFF_FFFF_FFFF_FFF8, 64'h200, 3, 1'b0);

    preload(4);
    start = 1'b1; src_addr = 64'h0; dst_addr = 64'h100; count = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid/in_write", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid/write_gated", {62'd0, mem_read, mem_write}, 64'd0);
    @(posedge clk); #1;
    check("rst_mid/status", {45'd0, busy, done, err, words_done}, 64'd0);
    check("rst_mid/bus", address | mem_wdata, 64'd0);
    check("rst_mid/word0", mem[8'h20], 64'd0);
    check("rst_mid/word1", mem[8'h21], 64'd1);
    check("rst_mid/word2", mem[8'h22], img[8'h22]);
    reset_n = 1'b1;
    dc = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) dc++;
    end
    check("rst_mid/no_done", 64'(dc), 64'd0);

    for (int r = 0; r < 6; r++) begin
      preload(0);
      run($sformatf("rand%0d", r), 64'($urandom_range(0, 255)) << 3,
          64'($urandom_range(0, 255)) << 3, $urandom_range(1, 6), r[0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
